// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive checker for the one-hot traffic light bus. Decodes the current phase,
//   measures how long each phase is held, and flags encoding, ordering and dwell
//   faults once the G->Y->R sequence has been acquired. Never drives the lights.
//
// Optional feature macro: TLM_STICKY_EN (adds err_clr_i / err_sticky_o).
//
// Ports
//   clk           in   1  clock, rising edge
//   rst           in   1  synchronous reset, active-high
//   lights_i      in   3  [0]=green [1]=yellow [2]=red
//   phase_o       out  2  0=GREEN 1=YELLOW 2=RED 3=INVALID (last sample)
//   locked_o      out  1  sequence acquired, dwell checking active
//   cycle_done_o  out  1  pulse: locked R->G with correct red dwell
//   err_onehot_o  out  1  pulse: lights not exactly one-hot
//   err_order_o   out  1  pulse: illegal phase transition
//   err_dwell_o   out  1  pulse: phase dwell wrong while locked
//   err_count_o   out  8  saturating count of error pulses
//   err_clr_i     in   1  (TLM_STICKY_EN) clear sticky flags
//   err_sticky_o  out  3  (TLM_STICKY_EN) {dwell,order,onehot} sticky flags
module traffic_light_monitor #(
  parameter int unsigned GREEN_TICKS  = 4,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned RED_TICKS    = 6,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] lights_i,
  output logic [1:0] phase_o,
  output logic       locked_o,
  output logic       cycle_done_o,
  output logic       err_onehot_o,
  output logic       err_order_o,
  output logic       err_dwell_o,
  output logic [7:0] err_count_o
`ifdef TLM_STICKY_EN
  ,
  input  logic       err_clr_i,
  output logic [2:0] err_sticky_o
`endif
);

  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
  localparam logic [CNT_W-1:0]     RUN_MAX     = '1;

  typedef enum logic [1:0] {
    PH_GREEN   = 2'd0,
    PH_YELLOW  = 2'd1,
    PH_RED     = 2'd2,
    PH_INVALID = 2'd3
  } phase_e;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_TRACK   = 1'b1
  } state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  phase_e                 r_phase;
  phase_e                 w_phase;
  phase_e                 w_succ;
  logic [CNT_W-1:0]       r_run;
  logic [CNT_W-1:0]       w_run_nxt;
  logic [CNT_W-1:0]       w_expected;
  logic [ERR_CNT_W-1:0]   r_err_count;
  logic [ERR_CNT_W-1:0]   w_err_count_nxt;
  logic                   r_cycle_done;
  logic                   r_err_onehot;
  logic                   r_err_order;
  logic                   r_err_dwell;
  logic                   w_cycle_done;
  logic                   w_err_onehot;
  logic                   w_err_order;
  logic                   w_err_dwell;
  logic                   w_last_valid;
  logic                   w_change;
  logic                   w_legal;

  // Decode the light bus into a phase; anything not one-hot is INVALID.
  always_comb begin
    w_phase = PH_INVALID;
    case (lights_i)
      3'b001:  w_phase = PH_GREEN;
      3'b010:  w_phase = PH_YELLOW;
      3'b100:  w_phase = PH_RED;
      default: w_phase = PH_INVALID;
    endcase
  end

  // Legal successor and expected dwell of the phase currently being held.
  always_comb begin
    w_succ     = PH_INVALID;
    w_expected = '0;
    case (r_phase)
      PH_GREEN: begin
        w_succ     = PH_YELLOW;
        w_expected = CNT_W'(GREEN_TICKS);
      end
      PH_YELLOW: begin
        w_succ     = PH_RED;
        w_expected = CNT_W'(YELLOW_TICKS);
      end
      PH_RED: begin
        w_succ     = PH_GREEN;
        w_expected = CNT_W'(RED_TICKS);
      end
      default: begin
        w_succ     = PH_INVALID;
        w_expected = '0;
      end
    endcase
  end

  assign w_last_valid = (r_phase != PH_INVALID);
  assign w_change     = (w_phase != PH_INVALID) && w_last_valid && (w_phase != r_phase);
  assign w_legal      = w_change && (w_phase == w_succ);

  // Run length of the current phase, restarting at 1 whenever the phase changes.
  always_comb begin
    w_run_nxt = r_run;
    if (w_phase != r_phase) begin
      w_run_nxt = CNT_W'(1);
    end else if (r_run != RUN_MAX) begin
      w_run_nxt = r_run + CNT_W'(1);
    end
  end

  // Next state and error classification; the if-chain encodes onehot > order > dwell.
  always_comb begin
    w_state_nxt  = r_state;
    w_err_onehot = 1'b0;
    w_err_order  = 1'b0;
    w_err_dwell  = 1'b0;
    w_cycle_done = 1'b0;
    if (w_phase == PH_INVALID) begin
      w_err_onehot = 1'b1;
      w_state_nxt  = ST_ACQUIRE;
    end else if (w_change && !w_legal) begin
      w_err_order = 1'b1;
      w_state_nxt = ST_ACQUIRE;
    end else if (r_state == ST_ACQUIRE) begin
      if (w_legal) begin
        w_state_nxt = ST_TRACK;
      end
    end else begin
      if (w_legal) begin
        // A run beyond expected was already reported while stuck; only short runs flag here.
        if (r_run < w_expected) begin
          w_err_dwell = 1'b1;
        end else if ((r_run == w_expected) && (r_phase == PH_RED)) begin
          w_cycle_done = 1'b1;
        end
      end else if (r_run == w_expected) begin
        // Same phase held: this sample makes the run one longer than expected.
        w_err_dwell = 1'b1;
      end
    end
  end

  always_comb begin
    w_err_count_nxt = r_err_count;
    if ((w_err_onehot || w_err_order || w_err_dwell) && (r_err_count != ERR_CNT_MAX)) begin
      w_err_count_nxt = r_err_count + ERR_CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACQUIRE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase tracking and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase      <= PH_INVALID;
      r_run        <= '0;
      r_err_count  <= '0;
      r_cycle_done <= 1'b0;
      r_err_onehot <= 1'b0;
      r_err_order  <= 1'b0;
      r_err_dwell  <= 1'b0;
    end else begin
      r_phase      <= w_phase;
      r_run        <= w_run_nxt;
      r_err_count  <= w_err_count_nxt;
      r_cycle_done <= w_cycle_done;
      r_err_onehot <= w_err_onehot;
      r_err_order  <= w_err_order;
      r_err_dwell  <= w_err_dwell;
    end
  end

  assign phase_o      = r_phase;
  assign locked_o     = (r_state == ST_TRACK);
  assign cycle_done_o = r_cycle_done;
  assign err_onehot_o = r_err_onehot;
  assign err_order_o  = r_err_order;
  assign err_dwell_o  = r_err_dwell;
  assign err_count_o  = r_err_count;

`ifdef TLM_STICKY_EN
  logic [2:0] r_sticky;

  // Sticky flags: a new error in the clearing cycle survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 3'b000;
    end else begin
      r_sticky <= (err_clr_i ? 3'b000 : r_sticky) | {w_err_dwell, w_err_order, w_err_onehot};
    end
  end

  assign err_sticky_o = r_sticky;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor
//   Directed bench for traffic_light_monitor with a behavioural reference model
//   compared against every output on every cycle, plus literal spot checks.
module tb_traffic_light_monitor;

  localparam int unsigned G_T = 4;
  localparam int unsigned Y_T = 2;
  localparam int unsigned R_T = 6;

  localparam logic [2:0] LG    = 3'b001;
  localparam logic [2:0] LY    = 3'b010;
  localparam logic [2:0] LR    = 3'b100;
  localparam logic [2:0] LBAD  = 3'b011;
  localparam logic [2:0] LNONE = 3'b000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] lights_i;
  logic [1:0] phase_o;
  logic       locked_o;
  logic       cycle_done_o;
  logic       err_onehot_o;
  logic       err_order_o;
  logic       err_dwell_o;
  logic [7:0] err_count_o;
`ifdef TLM_STICKY_EN
  logic       err_clr = 1'b0;
  logic [2:0] err_sticky_o;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  traffic_light_monitor #(
    .GREEN_TICKS (G_T),
    .YELLOW_TICKS(Y_T),
    .RED_TICKS   (R_T),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lights_i    (lights_i),
    .phase_o     (phase_o),
    .locked_o    (locked_o),
    .cycle_done_o(cycle_done_o),
    .err_onehot_o(err_onehot_o),
    .err_order_o (err_order_o),
    .err_dwell_o (err_dwell_o),
    .err_count_o (err_count_o)
`ifdef TLM_STICKY_EN
    ,
    .err_clr_i   (err_clr),
    .err_sticky_o(err_sticky_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase index 0=G 1=Y 2=R 3=none; length in plain integer cycles.
  int  m_prev    = 3;
  int  m_len     = 0;
  int  m_cnt     = 0;
  bit  m_locked  = 1'b0;
  bit  m_flagged = 1'b0;
  int  e_phase   = 3;
  bit  e_done    = 1'b0;
  bit  e_oh      = 1'b0;
  bit  e_ord     = 1'b0;
  bit  e_dw      = 1'b0;
  logic [2:0] e_sticky = 3'b000;

  function automatic int decode(input logic [2:0] l);
    if (l == LG) return 0;
    if (l == LY) return 1;
    if (l == LR) return 2;
    return 3;
  endfunction

  function automatic int dwell_of(input int p);
    if (p == 0) return int'(G_T);
    if (p == 1) return int'(Y_T);
    return int'(R_T);
  endfunction

  task automatic model_step();
    int ph;
    bit oh, ord, dw, dn;
    if (rst) begin
      m_prev = 3; m_len = 0; m_cnt = 0; m_locked = 0; m_flagged = 0;
      e_done = 0; e_oh = 0; e_ord = 0; e_dw = 0; e_sticky = 3'b000;
    end else begin
      ph = decode(lights_i);
      oh = 0; ord = 0; dw = 0; dn = 0;
      if (ph == 3) begin
        oh = 1; m_locked = 0;
      end else if (m_prev != 3 && ph != m_prev) begin
        if (ph != (m_prev + 1) % 3) begin
          ord = 1; m_locked = 0;
        end else if (!m_locked) begin
          m_locked = 1;
        end else if (m_len != dwell_of(m_prev)) begin
          dw = !m_flagged;
        end else begin
          dn = (m_prev == 2);
        end
      end else if (m_locked && ph == m_prev && (m_len + 1) > dwell_of(ph) && !m_flagged) begin
        dw = 1; m_flagged = 1;
      end
      if (ph != m_prev) begin
        m_len = 1; m_flagged = 0;
      end else begin
        m_len++;
      end
      m_prev = ph;
      if (oh || ord || dw) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      e_done = dn; e_oh = oh; e_ord = ord; e_dw = dw;
`ifdef TLM_STICKY_EN
      e_sticky = (err_clr ? 3'b000 : e_sticky) | {dw, ord, oh};
`endif
    end
    e_phase = m_prev;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("phase",      32'(phase_o),      32'(e_phase));
      check("locked",     32'(locked_o),     32'(m_locked));
      check("cycle_done", 32'(cycle_done_o), 32'(e_done));
      check("err_onehot", 32'(err_onehot_o), 32'(e_oh));
      check("err_order",  32'(err_order_o),  32'(e_ord));
      check("err_dwell",  32'(err_dwell_o),  32'(e_dw));
      check("err_count",  32'(err_count_o),  32'(m_cnt));
`ifdef TLM_STICKY_EN
      check("err_sticky", 32'(err_sticky_o), 32'(e_sticky));
`endif
    end
  end

  task automatic drive(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lights_i = l;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    lights_i = LR;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_phase",  32'(phase_o),     32'd3);
    check("rst_locked", 32'(locked_o),    32'd0);
    check("rst_count",  32'(err_count_o), 32'd0);

    // Acquire: R x7 then G locks; no dwell check on the red just left.
    @(negedge clk); rst = 1'b0; lights_i = LR;
    drive(LR, 6);
    drive(LG, 1); settle();
    check("lock_first_g",   32'(locked_o),     32'd1);
    check("no_done_on_lock", 32'(cycle_done_o), 32'd0);

    // Full correct cycle: done pulse after the second R->G.
    drive(LG, 3); drive(LY, 2); drive(LR, 6); drive(LG, 1); settle();
    check("cycle_done", 32'(cycle_done_o), 32'd1);
    check("count_clean", 32'(err_count_o), 32'd0);

    // Short green (3 cycles).
    drive(LG, 2); drive(LY, 1); settle();
    check("short_green_dwell", 32'(err_dwell_o), 32'd1);
    check("short_green_lock",  32'(locked_o),    32'd1);
    check("short_green_count", 32'(err_count_o), 32'd1);

    // Non-one-hot sample drops lock.
    drive(LY, 1); drive(LR, 6); drive(LBAD, 1); settle();
    check("bad_onehot", 32'(err_onehot_o), 32'd1);
    check("bad_locked", 32'(locked_o),     32'd0);
    check("bad_phase",  32'(phase_o),      32'd3);
    drive(LG, 2); drive(LY, 1); settle();
    check("relock", 32'(locked_o), 32'd1);

    // G -> R is illegal.
    drive(LY, 1); drive(LR, 6); drive(LG, 4); drive(LR, 1); settle();
    check("order_err",    32'(err_order_o), 32'd1);
    check("order_locked", 32'(locked_o),    32'd0);
    check("order_count",  32'(err_count_o), 32'd3);

    // Stuck yellow for 10 cycles: one pulse, after the 3rd sample only.
    drive(LG, 1); settle();
    check("relock2", 32'(locked_o), 32'd1);
    drive(LG, 3); drive(LY, 3); settle();
    check("stuck_pulse", 32'(err_dwell_o), 32'd1);
    check("stuck_count", 32'(err_count_o), 32'd4);
    drive(LY, 1); settle();
    check("stuck_once", 32'(err_dwell_o), 32'd0);
    drive(LY, 6); drive(LR, 1); settle();
    check("stuck_exit_quiet", 32'(err_dwell_o), 32'd0);
    check("stuck_exit_lock",  32'(locked_o),    32'd1);
    check("stuck_exit_count", 32'(err_count_o), 32'd4);

    // Error counter saturation with lights dark.
    drive(LNONE, 260); settle();
    check("count_sat", 32'(err_count_o), 32'd255);

`ifdef TLM_STICKY_EN
    check("sticky_all", 32'(err_sticky_o), 32'd7);
    @(negedge clk); err_clr = 1'b1; lights_i = LNONE; settle();
    check("sticky_err_wins", 32'(err_sticky_o), 32'd1);
    @(negedge clk); lights_i = LR; settle();
    check("sticky_cleared", 32'(err_sticky_o), 32'd0);
    @(negedge clk); err_clr = 1'b0; lights_i = LR;
`else
    @(negedge clk); lights_i = LR;
`endif

    // Reset in the middle of red.
    drive(LR, 2);
    @(negedge clk); rst = 1'b1; settle();
    check("midrst_phase",  32'(phase_o),      32'd3);
    check("midrst_locked", 32'(locked_o),     32'd0);
    check("midrst_count",  32'(err_count_o),  32'd0);
    check("midrst_errs",   32'({err_onehot_o, err_order_o, err_dwell_o, cycle_done_o}), 32'd0);
`ifdef TLM_STICKY_EN
    check("midrst_sticky", 32'(err_sticky_o), 32'd0);
`endif
    @(negedge clk); rst = 1'b0; lights_i = LR;
    drive(LG, 1); settle();
    check("post_rst_lock",  32'(locked_o),    32'd1);
    check("post_rst_count", 32'(err_count_o), 32'd0);
    drive(LG, 3); drive(LY, 2); drive(LR, 6); drive(LG, 1); settle();
    check("post_rst_done", 32'(cycle_done_o), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
